// File: rtl/axil_reg_slave.sv
// rtl/axil_reg_slave.sv - AXI4-Lite slave register bank with per-register write strobes
//
// Purpose: responder end of an AXI4-Lite bus exposing NUM_RW_REGS 32-bit control
//   registers to fabric logic. Writes commit one edge after both AW and W are held;
//   reads return data one edge after the AR handshake. Any address outside the
//   mapped range answers SLVERR (reads return zero, writes have no effect).
// Optional feature macro: AXIL_REG_SLAVE_RO_EN adds NUM_RO_REGS read-only status
//   words (ro_regs_in) directly after the RW block.
// Ports:
//   aclk, aresetn             clock (rising edge), asynchronous active-low reset
//   s_axil_aw*/w*/b*          write address, write data and write response channels
//   s_axil_ar*/r*             read address and read data channels
//   regs_out                  RW register contents, reg i at [32*i +: 32]
//   wr_pulse                  one-cycle strobe per committed in-range write, bit i = reg i
//   ro_regs_in                status words, word j at [32*j +: 32] (RO_EN build only)
module axil_reg_slave #(
  parameter int          ADDR_WIDTH  = 32,
  parameter int          NUM_RW_REGS = 8,
  parameter int          NUM_RO_REGS = 4,
  parameter logic [31:0] RESET_VAL   = 32'h0
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [ADDR_WIDTH-1:0]    s_axil_awaddr,
  input  logic                     s_axil_awvalid,
  output logic                     s_axil_awready,
  input  logic [31:0]              s_axil_wdata,
  input  logic [3:0]               s_axil_wstrb,
  input  logic                     s_axil_wvalid,
  output logic                     s_axil_wready,
  output logic [1:0]               s_axil_bresp,
  output logic                     s_axil_bvalid,
  input  logic                     s_axil_bready,
  input  logic [ADDR_WIDTH-1:0]    s_axil_araddr,
  input  logic                     s_axil_arvalid,
  output logic                     s_axil_arready,
  output logic [31:0]              s_axil_rdata,
  output logic [1:0]               s_axil_rresp,
  output logic                     s_axil_rvalid,
  input  logic                     s_axil_rready,
  output logic [32*NUM_RW_REGS-1:0] regs_out,
  output logic [NUM_RW_REGS-1:0]   wr_pulse
`ifdef AXIL_REG_SLAVE_RO_EN
  ,
  input  logic [32*NUM_RO_REGS-1:0] ro_regs_in
`endif
);

  localparam int              WW     = ADDR_WIDTH - 2;
  localparam logic [WW-1:0]   RW_END = WW'(NUM_RW_REGS);
  localparam logic [1:0]      OKAY   = 2'b00;
  localparam logic [1:0]      SLVERR = 2'b10;

  logic [31:0]            r_regs [NUM_RW_REGS];
  logic                   r_aw_held, r_w_held;
  logic [WW-1:0]          r_aw_word;
  logic [31:0]            r_wdata;
  logic [3:0]             r_wstrb;
  logic                   r_awready, r_wready, r_bvalid;
  logic [1:0]             r_bresp;
  logic [NUM_RW_REGS-1:0] r_wr_pulse;
  logic                   r_arready, r_rvalid;
  logic [31:0]            r_rdata;
  logic [1:0]             r_rresp;

  logic          w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs, w_commit, w_wr_ok;
  logic          w_aw_held_nxt, w_w_held_nxt, w_bvalid_nxt, w_rvalid_nxt;
  logic [WW-1:0] w_rd_word;
  logic [31:0]   w_rd_data;
  logic [1:0]    w_rd_resp;
  logic          w_unused;

  assign w_aw_hs  = s_axil_awvalid & r_awready;
  assign w_w_hs   = s_axil_wvalid & r_wready;
  assign w_b_hs   = r_bvalid & s_axil_bready;
  assign w_ar_hs  = s_axil_arvalid & r_arready;
  assign w_r_hs   = r_rvalid & s_axil_rready;
  // Both halves held since the previous edge: this edge performs the write.
  assign w_commit = r_aw_held & r_w_held;
  // Full word address is compared so high addresses never alias onto a register.
  assign w_wr_ok  = (r_aw_word < RW_END);

  assign w_aw_held_nxt = w_commit ? 1'b0 : (r_aw_held | w_aw_hs);
  assign w_w_held_nxt  = w_commit ? 1'b0 : (r_w_held | w_w_hs);
  assign w_bvalid_nxt  = w_commit ? 1'b1 : (w_b_hs ? 1'b0 : r_bvalid);
  assign w_rvalid_nxt  = w_ar_hs ? 1'b1 : (w_r_hs ? 1'b0 : r_rvalid);

  assign w_rd_word = s_axil_araddr[ADDR_WIDTH-1:2];

  always_comb begin
    w_rd_data = 32'h0;
    w_rd_resp = SLVERR;
    for (int i = 0; i < NUM_RW_REGS; i++) begin
      if (w_rd_word == WW'(i)) begin
        w_rd_data = r_regs[i];
        w_rd_resp = OKAY;
      end
    end
`ifdef AXIL_REG_SLAVE_RO_EN
    for (int j = 0; j < NUM_RO_REGS; j++) begin
      if (w_rd_word == WW'(NUM_RW_REGS + j)) begin
        w_rd_data = ro_regs_in[32*j +: 32];
        w_rd_resp = OKAY;
      end
    end
`endif
  end

`ifdef AXIL_REG_SLAVE_RO_EN
  assign w_unused = ^{s_axil_awaddr[1:0], s_axil_araddr[1:0]};
`else
  assign w_unused = ^{s_axil_awaddr[1:0], s_axil_araddr[1:0], (NUM_RO_REGS > 0)};
`endif

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < NUM_RW_REGS; i++) r_regs[i] <= RESET_VAL;
      r_aw_held  <= 1'b0;
      r_w_held   <= 1'b0;
      r_aw_word  <= '0;
      r_wdata    <= 32'h0;
      r_wstrb    <= 4'h0;
      r_awready  <= 1'b0;
      r_wready   <= 1'b0;
      r_bvalid   <= 1'b0;
      r_bresp    <= OKAY;
      r_wr_pulse <= '0;
      r_arready  <= 1'b0;
      r_rvalid   <= 1'b0;
      r_rdata    <= 32'h0;
      r_rresp    <= OKAY;
    end else begin
      r_aw_held <= w_aw_held_nxt;
      r_w_held  <= w_w_held_nxt;
      r_bvalid  <= w_bvalid_nxt;
      r_rvalid  <= w_rvalid_nxt;
      // Readies track the next-state flags so a held channel never accepts twice.
      r_awready <= ~w_aw_held_nxt & ~w_bvalid_nxt;
      r_wready  <= ~w_w_held_nxt & ~w_bvalid_nxt;
      r_arready <= ~w_rvalid_nxt;
      if (w_aw_hs) r_aw_word <= s_axil_awaddr[ADDR_WIDTH-1:2];
      if (w_w_hs) begin
        r_wdata <= s_axil_wdata;
        r_wstrb <= s_axil_wstrb;
      end
      if (w_commit) r_bresp <= w_wr_ok ? OKAY : SLVERR;
      for (int i = 0; i < NUM_RW_REGS; i++) begin
        r_wr_pulse[i] <= w_commit && (r_aw_word == WW'(i));
        if (w_commit && (r_aw_word == WW'(i))) begin
          for (int k = 0; k < 4; k++) begin
            if (r_wstrb[k]) r_regs[i][8*k +: 8] <= r_wdata[8*k +: 8];
          end
        end
      end
      // Read data is captured from pre-edge register state, so a same-edge commit
      // is not visible to this read.
      if (w_ar_hs) begin
        r_rdata <= w_rd_data;
        r_rresp <= w_rd_resp;
      end
    end
  end

  always_comb begin
    regs_out = '0;
    for (int i = 0; i < NUM_RW_REGS; i++) regs_out[32*i +: 32] = r_regs[i];
  end

  assign s_axil_awready = r_awready;
  assign s_axil_wready  = r_wready;
  assign s_axil_bvalid  = r_bvalid;
  assign s_axil_bresp   = r_bresp;
  assign s_axil_arready = r_arready;
  assign s_axil_rvalid  = r_rvalid;
  assign s_axil_rdata   = r_rdata;
  assign s_axil_rresp   = r_rresp;
  assign wr_pulse       = r_wr_pulse;

endmodule
